i2c_slave: RTL

Synchronous I2C target (slave) that sits directly downstream of the I2C master on the shared SCL/SDA bus. Oversamples both lines on its own clock, detects START/STOP, matches a fixed 7-bit address, ACKs, and delivers received bytes on a one-cycle valid strobe. With read support compiled in, it also serves bytes back to the master.

---
 rtl/i2c_slave_if.sv | 23 ++
 rtl/i2c_slave.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_if.sv
// Bus-side and user-side handshake signals of the I2C target, grouped for the slave and its user.
// SDA is open-drain and travels as a plain inout port on the slave itself.
`timescale 1ns/1ps
interface i2c_slave_if;
    logic       SCL;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       addr_match;
    logic       rd_wr_out;
    logic [7:0] tx_data_in;
    logic       tx_req;
    logic       busy;

    modport slave (
        input  SCL, tx_data_in,
        output rx_data, rx_valid, addr_match, rd_wr_out, tx_req, busy
    );

    modport master (
        output SCL, tx_data_in,
        input  rx_data, rx_valid, addr_match, rd_wr_out, tx_req, busy
    );
endinterface

// File: rtl/i2c_slave.sv
// Oversampling I2C target with a fixed 7-bit address; receives bytes and, when
// I2C_SLAVE_READ_EN is defined, also returns bytes to the master on reads.
//
// state    | meaning
// IDLE     | bus free, SDA released, waiting for START
// ADDR     | shifting in the 7-bit address and R/W bit
// ADDR_ACK | pulling SDA low for the address ACK
// RX       | shifting in a data byte from the master
// RX_ACK   | pulling SDA low for the data ACK
// TX       | driving a data byte to the master, MSB first
// TX_ACK   | SDA released, sampling the master's ACK/NACK
// WAIT     | not addressed or NACKed; ignoring the bus until START/STOP
`timescale 1ns/1ps
module i2c_slave #(
    parameter logic [6:0] ADDRESS = 7'h50
) (
    input  logic       clk_in,
    input  logic       n_rst,
    inout  wire        SDA,
    i2c_slave_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_RX,
        S_RX_ACK,
        S_TX,
        S_TX_ACK,
        S_WAIT
    } state_t;

    state_t     r_state;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_sda_oe;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_addr_match;
    logic       r_rd_wr;
    logic       r_busy;

    logic r_scl_s1, r_scl_s2, r_scl_d;
    logic r_sda_s1, r_sda_s2, r_sda_d;

    logic w_scl_rise, w_scl_fall, w_start, w_stop, w_addr_ok;

    always_ff @(posedge clk_in or negedge n_rst) begin
        if (!n_rst) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= bus.SCL;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= SDA;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & ~r_sda_d & r_sda_s2;

`ifdef I2C_SLAVE_READ_EN
    logic [7:0] r_tx_shift;
    logic       r_tx_req;
    assign w_addr_ok  = (r_shift[7:1] == ADDRESS);
    assign bus.tx_req = r_tx_req;
`else
    // Reads are refused at address time, so only a write can match.
    logic w_unused_tx;
    assign w_addr_ok   = (r_shift[7:1] == ADDRESS) && !r_shift[0];
    assign bus.tx_req  = 1'b0;
    assign w_unused_tx = ^bus.tx_data_in;
`endif

    always_ff @(posedge clk_in or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= 4'd0;
            r_shift      <= 8'h00;
            r_sda_oe     <= 1'b0;
            r_rx_data    <= 8'h00;
            r_rx_valid   <= 1'b0;
            r_addr_match <= 1'b0;
            r_rd_wr      <= 1'b0;
            r_busy       <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
            r_tx_shift   <= 8'h00;
            r_tx_req     <= 1'b0;
`endif
        end else begin
            r_rx_valid <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
            r_tx_req   <= 1'b0;
`endif
            if (w_start) begin
                r_state      <= S_ADDR;
                r_bit_cnt    <= 4'd0;
                r_busy       <= 1'b1;
                r_sda_oe     <= 1'b0;
                r_addr_match <= 1'b0;
            end else if (w_stop) begin
                r_state      <= S_IDLE;
                r_bit_cnt    <= 4'd0;
                r_busy       <= 1'b0;
                r_sda_oe     <= 1'b0;
                r_addr_match <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR: begin
                        if (w_scl_rise && r_bit_cnt != 4'd8) begin
                            r_shift   <= {r_shift[6:0], r_sda_s2};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                            r_bit_cnt <= 4'd0;
                            if (w_addr_ok) begin
                                r_state      <= S_ADDR_ACK;
                                r_sda_oe     <= 1'b1;
                                r_addr_match <= 1'b1;
                                r_rd_wr      <= r_shift[0];
`ifdef I2C_SLAVE_READ_EN
                                r_tx_req     <= r_shift[0];
`endif
                            end else begin
                                r_state <= S_WAIT;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_rd_wr) begin
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= 4'd0;
                                r_state   <= S_RX;
                            end
`ifdef I2C_SLAVE_READ_EN
                            else begin
                                r_tx_shift <= {bus.tx_data_in[6:0], 1'b0};
                                r_sda_oe   <= ~bus.tx_data_in[7];
                                r_bit_cnt  <= 4'd1;
                                r_state    <= S_TX;
                            end
`endif
                        end
                    end
                    S_RX: begin
                        if (w_scl_rise && r_bit_cnt != 4'd8) begin
                            r_shift   <= {r_shift[6:0], r_sda_s2};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                            r_rx_data  <= r_shift;
                            r_rx_valid <= 1'b1;
                            r_sda_oe   <= 1'b1;
                            r_state    <= S_RX_ACK;
                        end
                    end
                    S_RX_ACK: begin
                        if (w_scl_fall) begin
                            r_sda_oe  <= 1'b0;
                            r_bit_cnt <= 4'd0;
                            r_state   <= S_RX;
                        end
                    end
`ifdef I2C_SLAVE_READ_EN
                    S_TX: begin
                        if (w_scl_fall) begin
                            if (r_bit_cnt != 4'd8) begin
                                r_sda_oe   <= ~r_tx_shift[7];
                                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                                r_bit_cnt  <= r_bit_cnt + 4'd1;
                            end else begin
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= 4'd0;
                                r_state   <= S_TX_ACK;
                            end
                        end
                    end
                    // bit_cnt = 1 marks an ACKed byte; the next byte is loaded on the following fall.
                    S_TX_ACK: begin
                        if (w_scl_rise) begin
                            if (r_sda_s2) begin
                                r_state <= S_WAIT;
                            end else begin
                                r_tx_req  <= 1'b1;
                                r_bit_cnt <= 4'd1;
                            end
                        end else if (w_scl_fall && r_bit_cnt == 4'd1) begin
                            r_tx_shift <= {bus.tx_data_in[6:0], 1'b0};
                            r_sda_oe   <= ~bus.tx_data_in[7];
                            r_state    <= S_TX;
                        end
                    end
`endif
                    S_IDLE, S_WAIT: begin
                        r_sda_oe <= 1'b0;
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign SDA            = r_sda_oe ? 1'b0 : 1'bz;
    assign bus.rx_data    = r_rx_data;
    assign bus.rx_valid   = r_rx_valid;
    assign bus.addr_match = r_addr_match;
    assign bus.rd_wr_out  = r_rd_wr;
    assign bus.busy       = r_busy;

endmodule
